// File: rtl/xorshift_range_sampler_if.sv
// Stream/config bundle between the range sampler (master) and its environment (slave):
// PRNG word input, sample output stream and configuration controls.
interface xorshift_range_sampler_if #(
   parameter int OUT_W = 16
);
   logic             cfg_load;
   logic [OUT_W-1:0] cfg_range;
   logic [31:0]      rnd_in;
   logic             rnd_valid;
   logic             rnd_req;
   logic [OUT_W-1:0] smp_data;
   logic             smp_valid;
   logic             smp_ready;
   logic             busy;
   logic             cfg_err;

   modport master (
      input  cfg_load, cfg_range, rnd_in, rnd_valid, smp_ready,
      output rnd_req, smp_data, smp_valid, busy, cfg_err
   );

   modport slave (
      output cfg_load, cfg_range, rnd_in, rnd_valid, smp_ready,
      input  rnd_req, smp_data, smp_valid, busy, cfg_err
   );
endinterface

// File: rtl/xorshift_range_sampler.sv
// Mask-and-reject mapper from raw PRNG words to unbiased integers in [0, N), with FWFT output FIFO.
// Optional macro XORSHIFT_RANGE_SAMPLER_STATS_EN adds a saturating reject counter output rej_count.
module xorshift_range_sampler #(
   parameter int OUT_W      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   xorshift_range_sampler_if.master bus
`ifdef XORSHIFT_RANGE_SAMPLER_STATS_EN
   ,
   output logic [15:0] rej_count
`endif
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_M1C = CNT_W'(FIFO_DEPTH - 1);

   typedef enum logic [1:0] {IDLE, MASK, RUN} state_t;

   state_t           state_reg, state_next;
   logic [OUT_W-1:0] mask_reg, mask_next;
   logic [OUT_W-1:0] n_reg;
   logic             cfg_err_reg, cfg_err_next;
   logic [OUT_W-1:0] data_reg;
   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic [OUT_W-1:0] mem [FIFO_DEPTH];

   logic [OUT_W-1:0] cand;
   logic             flush, push, pop, pop_raw, reject, space;
   logic [CNT_W-1:0] cnt_after_pop;
   logic [PTR_W-1:0] rd_adv;
   logic             head_load;
   logic [OUT_W-1:0] head_next;

   generate
      if (OUT_W < 32) begin : g_unused_hi
         logic unused_rnd_hi;
         assign unused_rnd_hi = ^bus.rnd_in[31:OUT_W];
      end
   endgenerate

   assign cand    = bus.rnd_in[OUT_W-1:0] & mask_reg;
   assign pop_raw = (count_reg != '0) && bus.smp_ready;
   // A pop in the same cycle frees a slot, so a push at full is still legal then.
   assign space   = (count_reg != DEPTH_C) || pop_raw;

   always_comb begin
      state_next   = state_reg;
      mask_next    = mask_reg;
      cfg_err_next = cfg_err_reg;
      flush        = 1'b0;
      push         = 1'b0;
      pop          = 1'b0;
      reject       = 1'b0;
      if (bus.cfg_load) begin
         flush     = 1'b1;
         mask_next = '0;
         if (bus.cfg_range == '0) begin
            cfg_err_next = 1'b1;
            state_next   = IDLE;
         end else begin
            cfg_err_next = 1'b0;
            state_next   = MASK;
         end
      end else begin
         pop = pop_raw;
         case (state_reg)
            MASK: begin
               if (mask_reg >= n_reg - OUT_W'(1)) state_next = RUN;
               else mask_next = {mask_reg[OUT_W-2:0], 1'b1};
            end
            RUN: begin
               if (bus.rnd_valid && space) begin
                  if (cand < n_reg) push = 1'b1;
                  else reject = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.rnd_req   = (state_reg == RUN) &&
                          ((count_reg < DEPTH_M1C) || (count_reg == DEPTH_M1C && !push));
   assign bus.busy      = (state_reg == MASK);
   assign bus.cfg_err   = cfg_err_reg;
   assign bus.smp_valid = (count_reg != '0);
   assign bus.smp_data  = data_reg;

   // Output register tracks the FIFO head; it holds its value while the FIFO is empty.
   assign cnt_after_pop = count_reg - CNT_W'(pop);
   assign rd_adv        = rd_ptr_reg + PTR_W'(pop);
   assign head_load     = !flush && (push || (pop && cnt_after_pop != '0));
   assign head_next     = (cnt_after_pop == '0) ? cand : mem[rd_adv];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg] <= cand;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         mask_reg    <= '0;
         n_reg       <= '0;
         cfg_err_reg <= 1'b0;
         data_reg    <= '0;
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         count_reg   <= '0;
      end else begin
         state_reg   <= state_next;
         mask_reg    <= mask_next;
         cfg_err_reg <= cfg_err_next;
         if (bus.cfg_load) n_reg <= bus.cfg_range;
         if (head_load) data_reg <= head_next;
         if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
         end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            rd_ptr_reg <= rd_adv;
            case ({push, pop})
               2'b10:   count_reg <= count_reg + CNT_W'(1);
               2'b01:   count_reg <= count_reg - CNT_W'(1);
               default: count_reg <= count_reg;
            endcase
         end
      end
   end

`ifdef XORSHIFT_RANGE_SAMPLER_STATS_EN
   logic [15:0] rej_count_reg;

   always_ff @(posedge clk) begin
      if (rst || bus.cfg_load) rej_count_reg <= '0;
      else if (reject && rej_count_reg != 16'hFFFF) rej_count_reg <= rej_count_reg + 16'd1;
   end

   assign rej_count = rej_count_reg;
`endif
endmodule

// File: tb/tb_xorshift_range_sampler.sv
// Directed bench for xorshift_range_sampler: vector table plus hand-written FIFO/config sequences.
module tb_xorshift_range_sampler;
   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   exp_rej;

   xorshift_range_sampler_if #(.OUT_W(16)) bus ();

`ifdef XORSHIFT_RANGE_SAMPLER_STATS_EN
   logic [15:0] rej_count;
   xorshift_range_sampler #(.OUT_W(16), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .bus(bus), .rej_count(rej_count)
   );
`else
   xorshift_range_sampler #(.OUT_W(16), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] n;
      logic [31:0] word;
      logic        acc;
      logic [15:0] data;
      int          busy;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end else begin
         $display("ok   %s value=0x%0h", name, act);
      end
   endtask

   // Called at a falling edge; returns at a falling edge with busy low (bounded).
   task automatic do_cfg(input logic [15:0] n, output int busy_cycles);
      bus.cfg_load  = 1'b1;
      bus.cfg_range = n;
      @(negedge clk);
      bus.cfg_load = 1'b0;
      chk("flush_valid", 32'(bus.smp_valid), 32'd0);
      busy_cycles = 0;
      while (bus.busy && busy_cycles < 40) begin
         busy_cycles++;
         @(negedge clk);
      end
   endtask

   task automatic apply_word(input logic [31:0] w);
      bus.rnd_valid = 1'b1;
      bus.rnd_in    = w;
      @(negedge clk);
      bus.rnd_valid = 1'b0;
   endtask

   initial begin
      int b;
      int cur_n;
      int got;
      logic [31:0] w;
      logic [15:0] q[$];

      checks  = 0;
      errors  = 0;
      exp_rej = 0;
      vecs[0]  = '{16'd10,     32'h1234_0003, 1'b1, 16'h0003, 5};
      vecs[1]  = '{16'd10,     32'h0000_000C, 1'b0, 16'h0000, 5};
      vecs[2]  = '{16'd10,     32'h0000_0009, 1'b1, 16'h0009, 5};
      vecs[3]  = '{16'd10,     32'hFFFF_FFFF, 1'b0, 16'h0000, 5};
      vecs[4]  = '{16'd10,     32'h0000_0010, 1'b1, 16'h0000, 5};
      vecs[5]  = '{16'd16,     32'hABCD_1235, 1'b1, 16'h0005, 5};
      vecs[6]  = '{16'd16,     32'h0000_00FF, 1'b1, 16'h000F, 5};
      vecs[7]  = '{16'd1,      32'hDEAD_BEEF, 1'b1, 16'h0000, 1};
      vecs[8]  = '{16'd1,      32'h0000_FFFF, 1'b1, 16'h0000, 1};
      vecs[9]  = '{16'd5,      32'h0000_0004, 1'b1, 16'h0004, 4};
      vecs[10] = '{16'd5,      32'h0000_0006, 1'b0, 16'h0000, 4};
      vecs[11] = '{16'd5,      32'h0000_000D, 1'b0, 16'h0000, 4};
      vecs[12] = '{16'd5,      32'h0000_0008, 1'b1, 16'h0000, 4};
      vecs[13] = '{16'h8000,   32'h0000_FFFF, 1'b1, 16'h7FFF, 16};
      vecs[14] = '{16'hFFFF,   32'h0001_FFFF, 1'b0, 16'h0000, 17};
      vecs[15] = '{16'hFFFF,   32'h0000_FFFE, 1'b1, 16'hFFFE, 17};

      rst           = 1'b1;
      bus.cfg_load  = 1'b0;
      bus.cfg_range = '0;
      bus.rnd_in    = '0;
      bus.rnd_valid = 1'b0;
      bus.smp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset_smp_valid", 32'(bus.smp_valid), 32'd0);
      chk("reset_smp_data",  32'(bus.smp_data),  32'd0);
      chk("reset_rnd_req",   32'(bus.rnd_req),   32'd0);
      chk("reset_busy",      32'(bus.busy),      32'd0);
      chk("reset_cfg_err",   32'(bus.cfg_err),   32'd0);
`ifdef XORSHIFT_RANGE_SAMPLER_STATS_EN
      chk("reset_rej_count", 32'(rej_count), 32'd0);
`endif

      // Vector table: reconfigure when N changes, then one word per row.
      cur_n = -1;
      for (int i = 0; i < 16; i++) begin
         if (int'(vecs[i].n) != cur_n) begin
            do_cfg(vecs[i].n, b);
            chk($sformatf("busy_cycles_n%0d", vecs[i].n), 32'(b), 32'(vecs[i].busy));
            chk("rnd_req_run", 32'(bus.rnd_req), 32'd1);
            cur_n   = int'(vecs[i].n);
            exp_rej = 0;
         end
         apply_word(vecs[i].word);
         chk($sformatf("vec%0d_push", i), 32'(bus.smp_valid), 32'(vecs[i].acc));
         if (vecs[i].acc) chk($sformatf("vec%0d_data", i), 32'(bus.smp_data), 32'(vecs[i].data));
         else exp_rej++;
`ifdef XORSHIFT_RANGE_SAMPLER_STATS_EN
         chk($sformatf("vec%0d_rej_count", i), 32'(rej_count), 32'(exp_rej));
`endif
         @(negedge clk);
      end

      // N=16: every word accepted, delivered in order.
      do_cfg(16'd16, b);
      chk("busy_cycles_n16b", 32'(b), 32'd5);
      got = 0;
      for (int i = 0; i < 200; i++) begin
         w = $urandom;
         bus.rnd_valid = 1'b1;
         bus.rnd_in    = w;
         q.push_back({12'h000, w[3:0]});
         @(negedge clk);
         if (bus.smp_valid) begin
            got++;
            chk("rand_data", 32'(bus.smp_data), 32'(q.pop_front()));
         end
      end
      bus.rnd_valid = 1'b0;
      chk("rand_count", 32'(got), 32'd200);
`ifdef XORSHIFT_RANGE_SAMPLER_STATS_EN
      chk("rand_rej_count", 32'(rej_count), 32'd0);
`endif
      @(negedge clk);

      // Backpressure: fill to 4, rnd_req drops, extra word dropped, drain in order.
      bus.smp_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         bus.rnd_valid = 1'b1;
         bus.rnd_in    = 32'(i);
         #1;
         chk($sformatf("fill_rnd_req_cnt%0d", i - 1), 32'(bus.rnd_req), (i == 4) ? 32'd0 : 32'd1);
         @(negedge clk);
      end
      bus.rnd_valid = 1'b1;
      bus.rnd_in    = 32'h0000_0007;
      #1;
      chk("full_rnd_req", 32'(bus.rnd_req), 32'd0);
      @(negedge clk);
      bus.rnd_valid = 1'b0;
`ifdef XORSHIFT_RANGE_SAMPLER_STATS_EN
      chk("drop_not_counted", 32'(rej_count), 32'd0);
`endif
      bus.smp_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("drain%0d_valid", i), 32'(bus.smp_valid), 32'd1);
         chk($sformatf("drain%0d_data", i),  32'(bus.smp_data),  32'(i));
         @(negedge clk);
      end
      chk("drain_empty", 32'(bus.smp_valid), 32'd0);

      // Mid-run reconfigure discards buffered samples.
      bus.smp_ready = 1'b0;
      apply_word(32'h0000_000A);
      apply_word(32'h0000_000B);
      apply_word(32'h0000_000C);
      chk("pre_cfg_head", 32'(bus.smp_data), 32'h0000_000A);
      do_cfg(16'd5, b);
      chk("busy_cycles_n5b", 32'(b), 32'd4);
      bus.smp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("old_samples_gone", 32'(bus.smp_valid), 32'd0);
      apply_word(32'h0000_0003);
      chk("post_cfg_valid", 32'(bus.smp_valid), 32'd1);
      chk("post_cfg_data",  32'(bus.smp_data),  32'd3);
      @(negedge clk);

      // N=0 error, then recovery with N=3.
      do_cfg(16'd0, b);
      chk("n0_busy_cycles", 32'(b), 32'd0);
      chk("n0_cfg_err",     32'(bus.cfg_err), 32'd1);
      chk("n0_rnd_req",     32'(bus.rnd_req), 32'd0);
      apply_word(32'h0000_0001);
      chk("n0_ignored",     32'(bus.smp_valid), 32'd0);
      do_cfg(16'd3, b);
      chk("n3_busy_cycles", 32'(b), 32'd3);
      chk("n3_cfg_err",     32'(bus.cfg_err), 32'd0);
      apply_word(32'h0000_0002);
      chk("n3_valid", 32'(bus.smp_valid), 32'd1);
      chk("n3_data",  32'(bus.smp_data),  32'd2);
      @(negedge clk);
      apply_word(32'h0000_0003);
      chk("n3_reject", 32'(bus.smp_valid), 32'd0);

      // Reset with samples buffered.
      bus.smp_ready = 1'b0;
      apply_word(32'h0000_0001);
      apply_word(32'h0000_0000);
      chk("pre_rst_valid", 32'(bus.smp_valid), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_smp_valid", 32'(bus.smp_valid), 32'd0);
      chk("mid_rst_smp_data",  32'(bus.smp_data),  32'd0);
      chk("mid_rst_rnd_req",   32'(bus.rnd_req),   32'd0);
      chk("mid_rst_busy",      32'(bus.busy),      32'd0);
`ifdef XORSHIFT_RANGE_SAMPLER_STATS_EN
      chk("mid_rst_rej_count", 32'(rej_count), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
